// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared widths and read-tag type for the two-requester RAM arbiter
package ram_arb_pkg;
    localparam int RAM_ADDR_W = 6;
    localparam int RAM_DATA_W = 8;
    localparam int RAM_ID_W = 1;
    typedef struct packed {
        logic valid;
        logic [RAM_ID_W-1:0] id;
    } tag_t;
endpackage

// File: rtl/ram_arb_rdpipe.sv
// ram_arb_rdpipe: read-tag shift register of depth RD_LAT+1, aligned with registered RAM read data
module ram_arb_rdpipe
    import ram_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_in,
    output tag_t tag_out
);
    tag_t [RD_LAT:0] pipe;
    // shift tags one stage per edge; reset drops all in-flight reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pipe <= '0;
        else pipe <= {pipe[RD_LAT-1:0], tag_in};
    end
    assign tag_out = pipe[RD_LAT];
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester arbiter for a 64x8 single-port RAM (RAM_ARB_FIXED_PRIO_EN selects fixed priority)
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  r0_valid,
    output logic                  r0_ready,
    input  logic                  r0_we,
    input  logic [RAM_ADDR_W-1:0] r0_addr,
    input  logic [RAM_DATA_W-1:0] r0_wdata,
    output logic                  r0_rvalid,
    output logic [RAM_DATA_W-1:0] r0_rdata,
    input  logic                  r1_valid,
    output logic                  r1_ready,
    input  logic                  r1_we,
    input  logic [RAM_ADDR_W-1:0] r1_addr,
    input  logic [RAM_DATA_W-1:0] r1_wdata,
    output logic                  r1_rvalid,
    output logic [RAM_DATA_W-1:0] r1_rdata,
    output logic                  ram_we,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [RAM_DATA_W-1:0] ram_din,
    input  logic [RAM_DATA_W-1:0] ram_dout
);
    logic g0, g1, acc;
    logic sel_we;
    logic [RAM_ADDR_W-1:0] sel_addr;
    logic [RAM_DATA_W-1:0] sel_wdata;
    tag_t tag_in, tag_out;
`ifdef RAM_ARB_FIXED_PRIO_EN
    assign g0 = r0_valid;
`else
    logic last;
    assign g0 = r0_valid && (!r1_valid || last);
    // remember who was served last so a tie goes to the other requester
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last <= 1'b1;
        else if (acc) last <= r1_ready;
    end
`endif
    assign g1 = r1_valid && !g0;
    assign r0_ready = g0 && !rst;
    assign r1_ready = g1 && !rst;
    assign acc = r0_ready || r1_ready;
    assign sel_we = r1_ready ? r1_we : r0_we;
    assign sel_addr = r1_ready ? r1_addr : r0_addr;
    assign sel_wdata = r1_ready ? r1_wdata : r0_wdata;
    assign tag_in = '{valid: acc && !sel_we, id: RAM_ID_W'(r1_ready)};
    // register the winning command; idle cycles only drop the write enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_we <= 1'b0;
            ram_addr <= '0;
            ram_din <= '0;
        end else begin
            ram_we <= acc && sel_we;
            if (acc) begin
                ram_addr <= sel_addr;
                ram_din <= sel_wdata;
            end
        end
    end
    ram_arb_rdpipe #(.RD_LAT(RD_LAT)) u_rdpipe (
        .clk(clk),
        .rst(rst),
        .tag_in(tag_in),
        .tag_out(tag_out)
    );
    // capture RAM data when a read tag emerges and strobe the owning requester
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r0_rvalid <= 1'b0;
            r1_rvalid <= 1'b0;
            r0_rdata <= '0;
            r1_rdata <= '0;
        end else begin
            r0_rvalid <= tag_out.valid && (tag_out.id == RAM_ID_W'(0));
            r1_rvalid <= tag_out.valid && (tag_out.id == RAM_ID_W'(1));
            if (tag_out.valid) begin
                r0_rdata <= ram_dout;
                r1_rdata <= ram_dout;
            end
        end
    end
endmodule
